// File: rtl/frame_rr_if.sv
// Stream bundle between NUM_SRC requester streams and the shared frame datapath.
// The master modport is the arbiter's view of the bundle; the slave modport is the environment's view.
interface frame_rr_if #(
  parameter int NUM_SRC = 2
);
  logic [NUM_SRC-1:0]    s_tvalid;
  logic [NUM_SRC-1:0]    s_tready;
  logic [NUM_SRC*32-1:0] s_tdata;
  logic [NUM_SRC-1:0]    s_tlast;
  logic [NUM_SRC*4-1:0]  s_tuser;
  logic                  m_tvalid;
  logic                  m_tready;
  logic [31:0]           m_tdata;
  logic                  m_tlast;
  logic [3:0]            m_tuser;
  logic [1:0]            m_tid;

  modport master (
    input  s_tvalid, s_tdata, s_tlast, s_tuser, m_tready,
    output s_tready, m_tvalid, m_tdata, m_tlast, m_tuser, m_tid
  );

  modport slave (
    output s_tvalid, s_tdata, s_tlast, s_tuser, m_tready,
    input  s_tready, m_tvalid, m_tdata, m_tlast, m_tuser, m_tid
  );
endinterface

// File: rtl/frame_rr_arbiter.sv
// Frame-granular round-robin arbiter feeding one shared 32-bit stream datapath,
// with a max-frame-length watchdog that truncates and drains runaway frames.
module frame_rr_arbiter #(
  parameter int NUM_SRC   = 2,
  parameter int MAX_BEATS = 384
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_en,
  frame_rr_if.master         bus,
  output logic               busy,
  output logic               trunc_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, FWD = 2'd1, DRAIN = 2'd2} state_t;

  state_t             state;
  logic [1:0]         grant;
  logic [1:0]         ptr;
  logic [9:0]         beat_cnt;
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] gnt_oh;
  logic               sel_valid;
  logic               sel_last;
  logic [31:0]        sel_data;
  logic [3:0]         sel_user;
  logic               at_limit;
  logic [1:0]         next_ptr;

  // Rotate the request vector so bit 0 is the current priority holder, then take the first set bit.
  function automatic logic [1:0] rr_pick(input logic [NUM_SRC-1:0] r, input logic [1:0] start);
    logic [2*NUM_SRC-1:0] dbl;
    logic [NUM_SRC-1:0]   rot;
    logic [1:0]           sel;
    logic                 found;
    int                   s;
    dbl   = {r, r} >> start;
    rot   = dbl[NUM_SRC-1:0];
    sel   = 2'd0;
    found = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      s = int'(start) + i;
      if (s >= NUM_SRC) s = s - NUM_SRC;
      if (!found && rot[i]) begin
        sel   = 2'(s);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return sel;
  endfunction

  assign req       = bus.s_tvalid & src_en;
  assign at_limit  = (beat_cnt == 10'(MAX_BEATS - 1));
  assign next_ptr  = (grant == 2'(NUM_SRC - 1)) ? 2'd0 : grant + 2'd1;
  assign bus.m_tid = grant;
  assign busy      = (state != IDLE);

  // Select the granted source's stream signals.
  always_comb begin
    gnt_oh    = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = 32'd0;
    sel_user  = 4'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant == 2'(i)) begin
        gnt_oh[i] = 1'b1;
        sel_valid = bus.s_tvalid[i];
        sel_last  = bus.s_tlast[i];
        sel_data  = bus.s_tdata[32*i +: 32];
        sel_user  = bus.s_tuser[4*i +: 4];
      end else begin
        gnt_oh[i] = 1'b0;
      end
    end
  end

  // Pass-through in FWD, discard sink in DRAIN, everything quiet in IDLE.
  always_comb begin
    bus.s_tready = '0;
    bus.m_tvalid = 1'b0;
    bus.m_tdata  = 32'd0;
    bus.m_tlast  = 1'b0;
    bus.m_tuser  = 4'd0;
    case (state)
      FWD: begin
        bus.s_tready = gnt_oh & {NUM_SRC{bus.m_tready}};
        bus.m_tvalid = sel_valid;
        bus.m_tdata  = sel_data;
        bus.m_tlast  = sel_last | at_limit;
        bus.m_tuser  = sel_user;
      end
      DRAIN:   bus.s_tready = gnt_oh;
      default: bus.s_tready = '0;
    endcase
  end

  // Arbitration, beat accounting and watchdog state machine.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= 2'd0;
      ptr       <= 2'd0;
      beat_cnt  <= 10'd0;
      trunc_err <= 1'b0;
    end else begin
      trunc_err <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            grant    <= rr_pick(req, ptr);
            beat_cnt <= 10'd0;
            state    <= FWD;
          end
        end
        FWD: begin
          if (sel_valid && bus.m_tready) begin
            // A genuine tlast wins over the limit, so an exact-length frame is not an error.
            if (sel_last) begin
              ptr   <= next_ptr;
              state <= IDLE;
            end else if (at_limit) begin
              trunc_err <= 1'b1;
              ptr       <= next_ptr;
              state     <= DRAIN;
            end else begin
              beat_cnt <= beat_cnt + 10'd1;
            end
          end
        end
        DRAIN: begin
          if (sel_valid && sel_last) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/frame_rr_arbiter.md
Name: frame_rr_arbiter

Overview:
- Frame-granular round-robin arbiter that shares one 32-bit AXI-stream frame-processing datapath (e.g. the frame incrementer) between NUM_SRC requester streams.
- Grants one source at a time and holds the grant for a whole frame, up to tlast.
- Guards the shared datapath with a maximum-frame-length watchdog that truncates runaway frames and drains the rest of them.
- Sits between the RX interface FIFOs and the processing stage. Exports the granted source index so downstream logic can route responses.

Parameters:
- NUM_SRC, 2, number of requester streams; legal range 2..4.
- MAX_BEATS, 384, maximum 32-bit beats per frame before truncation; legal range 2..1023.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- src_en  in  NUM_SRC  per-source enable mask; sampled only at arbitration.
- s_tvalid  in  NUM_SRC  per-source valid.
- s_tready  out  NUM_SRC  per-source ready.
- s_tdata  in  NUM_SRC*32  packed data; source i occupies bits [32i+31:32i].
- s_tlast  in  NUM_SRC  per-source last.
- s_tuser  in  NUM_SRC*4  packed user; source i occupies bits [4i+3:4i].
- m_tvalid  out  1  to datapath, valid.
- m_tready  in  1  from datapath, ready.
- m_tdata  out  32  to datapath, data.
- m_tlast  out  1  to datapath, last; forced high on a truncated beat.
- m_tuser  out  4  to datapath, user; passed through from the granted source.
- m_tid  out  2  index of the granted source; stable for the whole frame.
- busy  out  1  high in FWD or DRAIN.
- trunc_err  out  1  one-cycle pulse when a frame is truncated.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE; grant, m_tid and beat_cnt clear to 0.
  - Round-robin pointer resets so source 0 has highest priority.
  - All s_tready, m_tvalid, busy and trunc_err are 0.
  - Reset mid-frame abandons the frame; no tlast is emitted.
- State IDLE:
  - Request vector is req = s_tvalid & src_en.
  - If req is nonzero, grant the first set bit searching upward from ptr and wrapping around.
  - Register grant into m_tid, set beat_cnt to 0, go to FWD.
  - All s_tready are 0 in IDLE. The first beat is forwarded in the cycle after the grant (one-cycle arbitration latency).
- State FWD: combinational pass-through from the granted source g.
  - m_tvalid = s_tvalid[g]; s_tready[g] = m_tready; all other s_tready = 0.
  - m_tdata and m_tuser follow source g.
  - m_tlast = s_tlast[g] OR (beat_cnt == MAX_BEATS-1).
- Beat accounting in FWD:
  - A beat is accepted when m_tvalid and m_tready are both high.
  - On each accepted beat, beat_cnt increments; it is 10 bits wide and never exceeds MAX_BEATS-1.
- Frame end in FWD:
  - Accepted beat with s_tlast[g]=1: set ptr = g+1 (mod NUM_SRC) and go to IDLE. This covers the case where tlast and the limit coincide; no trunc_err in that case.
  - Accepted beat at beat_cnt == MAX_BEATS-1 with s_tlast[g]=0: pulse trunc_err, set ptr = g+1 and go to DRAIN.
- State DRAIN:
  - s_tready[g] = 1 and m_tvalid = 0; the remaining input beats are discarded.
  - On an accepted input beat with s_tlast[g]=1, go to IDLE.
- Enable handling: src_en deasserting during FWD or DRAIN does not abort the frame; it only affects the next arbitration.
- Datapath backpressure: m_tready low in FWD stalls source g. There is no buffering, and AXI-stream stability is preserved end to end.
- Minimum spacing: back-to-back frames from different sources have exactly one idle cycle between them (the IDLE arbitration cycle).
- Single requester: a source that is the only requester is re-granted every frame.
- m_tid width is fixed at 2; unused upper values are never produced.
- Outputs outside FWD:
  - m_tdata = 0, m_tlast = 0, m_tuser = 0.
  - m_tid holds its last grant.

Test Plan:
- Fairness: sources 0 and 1 each stream continuous 4-beat frames with m_tready=1.
  - m_tid alternates 0,1,0,1.
  - Each frame appears on m_* intact, with one idle cycle between frames.
- Enable masking: src_en=2'b10 with both sources valid.
  - Only source 1 is granted.
  - s_tready[0] stays 0 throughout.
- Backpressure: 3-beat frame on source 0, with m_tready low for 5 cycles mid-frame.
  - m_tdata and m_tlast are held stable during the stall.
  - beat_cnt does not advance; the frame completes with 3 accepted beats.
- Truncation: MAX_BEATS=8, source 0 sends a 12-beat frame.
  - 8 beats are output with m_tlast on beat 8, and trunc_err pulses once.
  - The remaining 4 beats are consumed with m_tvalid=0.
  - Source 1 is granted next.
- Exact-length boundary: MAX_BEATS=8, 8-beat frame with tlast on beat 8.
  - m_tlast is asserted on beat 8, there is no trunc_err, and the state returns straight to IDLE.
- Reset mid-frame: rst asserted on beat 2 of a 6-beat frame.
  - The next cycle shows all s_tready and m_tvalid at 0 and m_tid at 0.
  - After rst deasserts, the first grant goes to source 0.
